// File: rtl/lock_pkg.sv
// Shared parameters and loader state encoding for the digital-lock programming path.
package lock_pkg;

    localparam int ADRS_WIDTH = 2;
    localparam int WORD_DEPTH = 2 ** ADRS_WIDTH;
    localparam int WORD_WIDTH = 8;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_COLLECT = 3'd1,
        LD_COMMIT  = 3'd2,
        LD_DONE    = 3'd3,
        LD_ERROR   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/code_buffer.sv
// Passcode staging register file: one indexed write port, one indexed read port.
module code_buffer
    import lock_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADRS_WIDTH-1:0] wr_idx,
    input  logic [WORD_WIDTH-1:0] wr_word,
    input  logic [ADRS_WIDTH-1:0] rd_idx,
    output logic [WORD_WIDTH-1:0] rd_word
);

    // Contents are meaningless until a load fills them, so no reset.
    logic [WORD_WIDTH-1:0] mem_q [WORD_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    assign rd_word = mem_q[rd_idx];

endmodule

// File: rtl/code_loader.sv
// Buffers a checksummed passcode stream and commits it to lock memory only when the checksum holds.
module code_loader
    import lock_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADRS_WIDTH-1:0] wr_adrs,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADRS_WIDTH:0] CNT_FULL = (ADRS_WIDTH+1)'(WORD_DEPTH);
    localparam logic [ADRS_WIDTH:0] CNT_ONE  = (ADRS_WIDTH+1)'(1);

    loader_state_e         state_q, state_d;
    logic [ADRS_WIDTH:0]   cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] chk_q, chk_d;
    logic                  in_ready_q, in_ready_d;
    logic                  we_q, we_d;
    logic [ADRS_WIDTH-1:0] wr_adrs_q, wr_adrs_d;
    logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic                  buf_we;
    logic [WORD_WIDTH-1:0] rd_word;

    assign xfer = in_valid && in_ready_q;

    // cnt counts data bytes while collecting, then is the next write index while committing.
    code_buffer u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (cnt_q[ADRS_WIDTH-1:0]),
        .wr_word (in_data),
        .rd_idx  (cnt_q[ADRS_WIDTH-1:0]),
        .rd_word (rd_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        err_d   = err_q;
        buf_we  = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d = LD_COLLECT;
                    cnt_d   = '0;
                    chk_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LD_COLLECT: begin
                if (abort) begin
                    state_d = LD_IDLE;
                end else if (xfer) begin
                    if (cnt_q == CNT_FULL) begin
                        // Low index bits are already 0 here, so word 0 is read this cycle.
                        if ((chk_q ^ in_data) == '0) begin
                            state_d = LD_COMMIT;
                            cnt_d   = CNT_ONE;
                        end else begin
                            state_d = LD_ERROR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        buf_we = 1'b1;
                        chk_d  = chk_q ^ in_data;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            LD_COMMIT: begin
                if (cnt_q == CNT_FULL) begin
                    state_d = LD_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LD_DONE:  state_d = LD_IDLE;
            LD_ERROR: state_d = LD_IDLE;
            default:  state_d = LD_IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        in_ready_d = (state_d == LD_COLLECT);
        we_d       = (state_d == LD_COMMIT);
        wr_adrs_d  = we_d ? cnt_q[ADRS_WIDTH-1:0] : '0;
        wr_data_d  = we_d ? rd_word : '0;
        busy_d     = (state_d != LD_IDLE);
        done_d     = (state_d == LD_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LD_IDLE;
            cnt_q      <= '0;
            chk_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wr_adrs_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            wr_adrs_q  <= wr_adrs_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign wr_adrs  = wr_adrs_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
